accum_ctrl: RTL and testbench
=============================

# accum_ctrl

One-hot sequencing controller for the adder/mux accumulate datapath. It holds a 3-bit one-hot state (IDLE=3'b001, ACCUM=3'b010, DONE=3'b100) that resets asynchronously to IDLE, and forms its own next state. It counts accumulate iterations and drives the datapath's accumulator clear and enable, its operand index, and the done/busy status. The block is the control stage that sits directly upstream of the datapath registers and consumes/produces the state vector.

## Interface
- CNT_W, 4, width of the length/index counter; run length is 0..2^CNT_W-1
- clk  in  1  clock; all flops rise-edge triggered
- CLRN  in  1  asynchronous active-low reset
- start  in  1  request to begin a run; sampled only in IDLE
- len  in  CNT_W  number of accumulate cycles; captured on accepted start
- state  out  3  current one-hot state
- nxt_state  out  3  combinational next state (D inputs of state flops)
- clr_acc  out  1  datapath accumulator clear (mux selects zero); = IDLE & start
- acc_en  out  1  accumulator load enable; = ACCUM
- idx  out  CNT_W  current iteration index, drives operand mux select
- busy  out  1  high in ACCUM or DONE
- done  out  1  one-cycle pulse, high in DONE

## Operation
- State register: the three flops reset asynchronously on CLRN=0. The state[0] flop presets to 1 and state[2:1] clear to 0. Reset value: state=3'b001. Reset release is synchronous to the next clk edge.
- Internal len_q (CNT_W bits) is loaded from len on an accepted start. Changes on len at any other time are ignored.
- IDLE:
  - start=0: stay in IDLE.
  - start=1 and len!=0: go to ACCUM, idx<=0, len_q<=len.
  - start=1 and len==0: go directly to DONE. No acc_en cycle occurs.
  - clr_acc = start (Mealy).
- ACCUM:
  - acc_en=1 every cycle.
  - idx==len_q-1: go to DONE, idx holds.
  - Otherwise stay in ACCUM, idx<=idx+1.
  - start is ignored.
- DONE: done=1, go to IDLE unconditionally, idx<=0. start is ignored; a start held high is accepted on the cycle after DONE.
- Illegal state (any value other than the three encodings):
  - nxt_state=3'b001.
  - clr_acc, acc_en, busy and done are all 0; they are decoded from exact encodings only.
  - idx<=0.
- idx arithmetic is unsigned CNT_W-bit. It never wraps in legal operation, because the max len is 2^CNT_W-1 and the terminal idx is len_q-1.
- Reset mid-run: state returns to IDLE immediately (asynchronously). idx=0, len_q=0. All outputs go to their reset values in the same instant, with no clk edge needed.

## Timing
- Reset values: state=001, nxt_state=001 (with start=0), idx=0, busy=0, done=0, acc_en=0, clr_acc=start.
- Latency for an accepted start at edge k with len=N>0:
  - ACCUM for N cycles after edge k, with idx 0..N-1 during those cycles.
  - DONE for the cycle after edge k+N.
  - IDLE after edge k+N+1.
- Total busy time: N+1 cycles.
- len=0: DONE for the cycle after edge k, IDLE after edge k+1. busy=1 for 1 cycle.
- clr_acc is combinational in the cycle before edge k. The datapath clears the accumulator at edge k, then first accumulates at edge k+1.
- Back-to-back runs: minimum spacing is one IDLE cycle between DONE and the next ACCUM.
- Exactly one state bit is high at every legal clk edge.

## Test plan
- Reset: assert CLRN=0 mid-clock with state=ACCUM, idx=5 -> state=001, idx=0 and busy=0 immediately, before any clk edge.
- Normal run: len=4, start pulse -> acc_en high 4 cycles with idx 0,1,2,3; done high exactly 1 cycle; state returns to 001; busy high for 5 cycles.
- Zero length: len=0, start -> state 001→100→001, acc_en never high, done pulses once.
- Max length with CNT_W=4: len=15 -> 15 acc_en cycles, idx ends at 14 with no wrap. Change len to 2 mid-run -> no effect on run length.
- start held high continuously with len=2 -> repeating pattern ACCUM, ACCUM, DONE, IDLE; clr_acc high only in the IDLE cycles.
- Force illegal state 3'b011 and 3'b000 via the state flops -> nxt_state=001, all control outputs 0, IDLE on next edge.

Source files
------------

// File: rtl/accum_ctrl.sv
// accum_ctrl: one-hot sequencing controller for the adder/mux accumulate
// datapath. Sequences IDLE -> ACCUM (len cycles) -> DONE -> IDLE, drives the
// accumulator clear/enable, the operand index, and the busy/done status.
module accum_ctrl #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             CLRN,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    output logic [2:0]       state,
    output logic [2:0]       nxt_state,
    output logic             clr_acc,
    output logic             acc_en,
    output logic [CNT_W-1:0] idx,
    output logic             busy,
    output logic             done
);

    // One-hot encodings; anything else is treated as illegal.
    typedef enum logic [2:0] {
        S_IDLE  = 3'b001,
        S_ACCUM = 3'b010,
        S_DONE  = 3'b100
    } state_e;

    // The state register is a plain vector so an illegal value can be held
    // and decoded; the enum supplies the legal encodings.
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] len_q, len_d;

    logic is_idle, is_accum, is_done;
    logic last_iter;

    // Exact-encoding decodes: illegal states assert none of these.
    always_comb begin
        is_idle  = (state_q == S_IDLE);
        is_accum = (state_q == S_ACCUM);
        is_done  = (state_q == S_DONE);
        // len_q is never zero while in ACCUM, so len_q-1 does not wrap there.
        last_iter = (idx_q == (len_q - CNT_W'(1)));
    end

    // Next-state, counter and length-capture logic.
    always_comb begin
        state_d = S_IDLE;
        idx_d   = '0;
        len_d   = len_q;
        case (state_q)
            S_IDLE: begin
                idx_d = '0;
                if (start) begin
                    len_d   = len;
                    state_d = (len != '0) ? S_ACCUM : S_DONE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACCUM: begin
                if (last_iter) begin
                    state_d = S_DONE;
                    idx_d   = idx_q;
                end else begin
                    state_d = S_ACCUM;
                    idx_d   = idx_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
            default: begin
                // Illegal encoding: recover to IDLE on the next edge.
                state_d = S_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // State, index and captured length registers; async clear to IDLE.
    always_ff @(posedge clk or negedge CLRN) begin
        if (!CLRN) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
        end
    end

    // Output drive: clr_acc is Mealy on start, the rest are Moore decodes.
    always_comb begin
        state     = state_q;
        nxt_state = state_d;
        clr_acc   = is_idle & start;
        acc_en    = is_accum;
        busy      = is_accum | is_done;
        done      = is_done;
        idx       = idx_q;
    end

endmodule

// File: tb/tb_accum_ctrl.sv
// tb_accum_ctrl: directed scenarios for accum_ctrl with an index scoreboard.
module tb_accum_ctrl;
  localparam int CNT_W = 4;
  localparam logic [2:0] IDLE  = 3'b001;
  localparam logic [2:0] ACCUM = 3'b010;
  localparam logic [2:0] DONE  = 3'b100;

  logic             clk = 1'b0;
  logic             CLRN;
  logic             start;
  logic [CNT_W-1:0] len;
  logic [2:0]       state;
  logic [2:0]       nxt_state;
  logic             clr_acc;
  logic             acc_en;
  logic [CNT_W-1:0] idx;
  logic             busy;
  logic             done;

  int n_cmp = 0;
  int n_err = 0;
  logic [CNT_W-1:0] exp_q[$];

  accum_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .CLRN(CLRN), .start(start), .len(len),
    .state(state), .nxt_state(nxt_state), .clr_acc(clr_acc),
    .acc_en(acc_en), .idx(idx), .busy(busy), .done(done)
  );

  // clock
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // pop an expected index whenever the datapath is enabled
  task automatic score_idx(input string name);
    logic [CNT_W-1:0] e;
    if (acc_en === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL %s unexpected acc_en: idx=%0d queue empty", name, idx);
      end else begin
        e = exp_q.pop_front();
        if (idx !== e) begin
          n_err++;
          $display("FAIL %s idx: got %0d expected %0d", name, idx, e);
        end
      end
    end
  endtask

  task automatic test_reset();
    CLRN = 1'b0; start = 1'b0; len = '0;
    tick(); tick();
    n_cmp++; if (state !== IDLE) begin n_err++; $display("FAIL reset state: got %b expected %b", state, IDLE); end
    n_cmp++; if (nxt_state !== IDLE) begin n_err++; $display("FAIL reset nxt_state: got %b expected %b", nxt_state, IDLE); end
    n_cmp++; if (idx !== '0) begin n_err++; $display("FAIL reset idx: got %0d expected 0", idx); end
    n_cmp++; if ({busy, done, acc_en, clr_acc} !== 4'b0000) begin n_err++; $display("FAIL reset outs: got %b expected 0000", {busy, done, acc_en, clr_acc}); end
    start = 1'b1; #1;
    n_cmp++; if (clr_acc !== 1'b1) begin n_err++; $display("FAIL reset clr_acc follows start: got %b expected 1", clr_acc); end
    start = 1'b0; #1;
    CLRN = 1'b1;
    tick();
    n_cmp++; if (state !== IDLE) begin n_err++; $display("FAIL post-reset state: got %b expected %b", state, IDLE); end
  endtask

  // one run of length n; optionally change len to 2 mid-run
  task automatic test_run(input int n, input bit change_len, input string name);
    logic [2:0] es;
    len = CNT_W'(n); start = 1'b1; #1;
    n_cmp++; if (clr_acc !== 1'b1) begin n_err++; $display("FAIL %s clr_acc: got %b expected 1", name, clr_acc); end
    for (int i = 0; i < n; i++) exp_q.push_back(CNT_W'(i));
    tick();
    start = 1'b0;
    len = change_len ? CNT_W'(len) : CNT_W'($urandom_range(0, 15));
    for (int j = 1; j <= n + 2; j++) begin
      if (change_len && j == 3) len = CNT_W'(2);
      es = (j <= n) ? ACCUM : ((j == n + 1) ? DONE : IDLE);
      n_cmp++; if (state !== es) begin n_err++; $display("FAIL %s state c%0d: got %b expected %b", name, j, state, es); end
      n_cmp++; if (busy !== (j <= n + 1)) begin n_err++; $display("FAIL %s busy c%0d: got %b expected %b", name, j, busy, (j <= n + 1)); end
      n_cmp++; if (done !== (j == n + 1)) begin n_err++; $display("FAIL %s done c%0d: got %b expected %b", name, j, done, (j == n + 1)); end
      n_cmp++; if (acc_en !== (j <= n)) begin n_err++; $display("FAIL %s acc_en c%0d: got %b expected %b", name, j, acc_en, (j <= n)); end
      if (j == n + 1 && n > 0) begin
        n_cmp++; if (idx !== CNT_W'(n - 1)) begin n_err++; $display("FAIL %s idx hold in DONE: got %0d expected %0d", name, idx, n - 1); end
      end
      if (j == n + 2) begin
        n_cmp++; if (idx !== '0) begin n_err++; $display("FAIL %s idx after DONE: got %0d expected 0", name, idx); end
      end
      score_idx(name);
      tick();
    end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL %s leftover: got %0d entries expected 0", name, exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [2:0] es;
    int ph;
    len = CNT_W'(2); start = 1'b1; #1;
    for (int j = 0; j < 12; j++) begin
      ph = j % 4;
      es = (ph == 0) ? IDLE : ((ph == 3) ? DONE : ACCUM);
      if (ph == 0) begin exp_q.push_back(CNT_W'(0)); exp_q.push_back(CNT_W'(1)); end
      n_cmp++; if (state !== es) begin n_err++; $display("FAIL b2b state c%0d: got %b expected %b", j, state, es); end
      n_cmp++; if (clr_acc !== (ph == 0)) begin n_err++; $display("FAIL b2b clr_acc c%0d: got %b expected %b", j, clr_acc, (ph == 0)); end
      score_idx("b2b");
      tick();
    end
    start = 1'b0;
    tick();
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL b2b leftover: got %0d entries expected 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_reset_mid_run();
    len = CNT_W'(8); start = 1'b1;
    tick();
    start = 1'b0;
    for (int j = 1; j < 6; j++) tick();
    n_cmp++; if (state !== ACCUM || idx !== CNT_W'(5)) begin n_err++; $display("FAIL midrst pre: got state %b idx %0d expected %b idx 5", state, idx, ACCUM); end
    #2 CLRN = 1'b0;
    #1;
    n_cmp++; if (state !== IDLE) begin n_err++; $display("FAIL midrst state: got %b expected %b", state, IDLE); end
    n_cmp++; if (idx !== '0) begin n_err++; $display("FAIL midrst idx: got %0d expected 0", idx); end
    n_cmp++; if ({busy, acc_en, done} !== 3'b000) begin n_err++; $display("FAIL midrst outs: got %b expected 000", {busy, acc_en, done}); end
    tick();
    CLRN = 1'b1;
    tick();
    n_cmp++; if (state !== IDLE) begin n_err++; $display("FAIL midrst after release: got %b expected %b", state, IDLE); end
  endtask

  task automatic test_illegal(input logic [2:0] bad);
    start = 1'b1;
    force dut.state_q = bad;
    #1;
    n_cmp++; if (nxt_state !== IDLE) begin n_err++; $display("FAIL illegal %b nxt_state: got %b expected %b", bad, nxt_state, IDLE); end
    n_cmp++; if ({clr_acc, acc_en, busy, done} !== 4'b0000) begin n_err++; $display("FAIL illegal %b outs: got %b expected 0000", bad, {clr_acc, acc_en, busy, done}); end
    start = 1'b0;
    release dut.state_q;
    tick();
    n_cmp++; if (state !== IDLE) begin n_err++; $display("FAIL illegal %b recover: got %b expected %b", bad, state, IDLE); end
    n_cmp++; if (idx !== '0) begin n_err++; $display("FAIL illegal %b idx: got %0d expected 0", bad, idx); end
  endtask

  initial begin
    test_reset();
    test_run(4, 1'b0, "normal");
    test_run(0, 1'b0, "zero_len");
    test_run(15, 1'b1, "max_len");
    test_run($urandom_range(1, 15), 1'b0, "rand_len");
    test_back_to_back();
    test_reset_mid_run();
    test_illegal(3'b011);
    test_illegal(3'b000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // absolute time bound
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end
endmodule
